fp_mult_iter: RTL and testbench
===============================

Name: fp_mult_iter

Overview:
- Parametrised, iterative IEEE-754-style floating-point multiplier. Successor to the combinational single-precision multiplier.
- Generalised exponent and mantissa widths, with valid/ready handshakes on input and output.
- Mantissa product built by a shift-add datapath, one multiplier bit per clock.
- Adds underflow and invalid flags and defined special-value handling. Sits in the ALU beside the integer units.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width; operand width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A {sign, exp, frac}.
- b  in  W  operand B.
- out_valid  out  1  product/flags valid.
- out_ready  in  1  consumer accepts result.
- product  out  W  result.
- overflow  out  1  result saturated to ±inf from finite inputs.
- underflow  out  1  nonzero finite result flushed to ±0.
- invalid  out  1  NaN operand, or inf×0.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, product=0, all flags 0.
- rst in any state aborts the operation; the next edge returns to IDLE with the reset values.
- States:
  - IDLE: in_ready=1. in_valid&in_ready captures a/b and goes to MUL; counter=0.
  - MUL: in_ready=0. Each cycle adds the shifted multiplicand when the current multiplier bit is 1. Runs exactly MAN_W+1 cycles, then goes to NORM.
  - NORM: one cycle. Normalise, round, compute exponent, apply special cases, register outputs, go to DONE.
  - DONE: out_valid=1; product and flags held stable. out_ready=1 goes to IDLE with out_valid=0. No new accept in the same cycle as DONE→IDLE.
- Latency: fixed. out_valid rises MAN_W+2 edges after the accepting edge (25 for defaults), including for special-value inputs. No back-to-back accept; throughput is one op per MAN_W+4 cycles minimum.
- Arithmetic:
  - Sign = sa^sb for every result, including zero, inf and overflow. Canonical NaN is the exception (sign 0).
  - exp==0 means zero: denormals are flushed to zero.
  - Significands have an implicit 1; the product is 2*(MAN_W+1) bits.
  - If the product MSB is set: shift right 1, exponent+1.
  - Exponent computed signed in EXP_W+2 bits: ea+eb-BIAS(+1).
  - Rounding carry-out renormalises (exponent+1).
  - Resulting exponent ≥ 2^EXP_W-1: ±inf, overflow=1.
  - Resulting exponent ≤ 0: ±0, underflow=1.
- Special cases, checked first:
  - Either operand NaN (exp all ones, frac≠0): product = canonical qNaN {0, all ones, 1 followed by zeros}, invalid=1.
  - inf×0: same canonical NaN, invalid=1.
  - inf×finite nonzero: ±inf, no flags.
  - Zero × finite: ±0, no flags.
- Flags are valid only with out_valid and are cleared on DONE→IDLE.

Optional Feature:
- Macro FP_MULT_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even using guard and sticky bits. Ties go to even; the carry can renormalise.
- Undefined: truncate; bits below the LSB are dropped and no rounding adder is built.
- All other behaviour and the latency are identical in both builds.

Test Plan:
- a=3f800000, b=418aa000 → product 418aa000, all flags 0, out_valid exactly 25 cycles after accept.
- a=c0000000, b=40400000 → c0c00000. Then a=00000000, b=418aa000 → 00000000, no flags.
- a=7f000000, b=40000000 → 7f800000, overflow=1. a=00800000, b=00800000 → 00000000, underflow=1.
- a=7f800000, b=00000000 → 7fc00000, invalid=1. a=ff800000, b=40000000 → ff800000, no flags.
- a=3fc00000, b=3f800001 → 3fc00002 with FP_MULT_ROUND_NEAREST_EN defined; 3fc00001 without it.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → product and out_valid stable, in_ready=0. Assert rst mid-MUL → IDLE, out_valid=0, in_ready=1 after the next edge, and a following op completes correctly.

Source files
------------

// File: rtl/fp_mult_iter.sv
// Iterative shift-add floating-point multiplier with valid/ready handshakes and IEEE-style flags.
// Optional build macro FP_MULT_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fp_mult_iter #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SW   = MAN_W + 1;
  localparam int unsigned PW   = 2 * SW;
  localparam int unsigned ES   = EXP_W + 2;
  localparam int unsigned CW   = $clog2(MAN_W + 1) + 1;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;
  localparam logic signed [ES-1:0] EMAX_S = ES'(EMAX);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_e;

  state_e         state_q;
  logic [W-1:0]   a_q, b_q;
  logic [PW-1:0]  acc_q, mcand_q;
  logic [SW-1:0]  mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           in_ready_q, out_valid_q;
  logic [W-1:0]   product_q;
  logic           overflow_q, underflow_q, invalid_q;

  // Normalise/round/special-case result, consumed in NORM
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb, mant, mant_r;
  logic                 sign, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic                 msb, carry;
  logic [PW-1:0]        norm;
  logic signed [ES-1:0] exp_s;
  logic [W-1:0]         res_d;
  logic                 ovf_d, unf_d, inv_d;
  logic                 unused_c;
`ifdef FP_MULT_ROUND_NEAREST_EN
  logic                 guard, sticky, round_up;
`endif

  always_comb begin
    ea     = a_q[MAN_W +: EXP_W];
    eb     = b_q[MAN_W +: EXP_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    sign   = a_q[W-1] ^ b_q[W-1];
    nan_a  = (ea == '1) && (fa != '0);
    nan_b  = (eb == '1) && (fb != '0);
    inf_a  = (ea == '1) && (fa == '0);
    inf_b  = (eb == '1) && (fb == '0);
    zero_a = (ea == '0);
    zero_b = (eb == '0);

    msb    = acc_q[PW-1];
    norm   = msb ? acc_q : (acc_q << 1);
    mant   = norm[PW-2 -: MAN_W];
`ifdef FP_MULT_ROUND_NEAREST_EN
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard & (sticky | mant[0]);
    {carry, mant_r} = {1'b0, mant} + (MAN_W+1)'(round_up);
    unused_c = norm[PW-1];
`else
    carry    = 1'b0;
    mant_r   = mant;
    unused_c = ^{norm[PW-1], norm[MAN_W:0]};
`endif
    exp_s = ES'(ea) + ES'(eb) - ES'(BIAS) + ES'(msb) + ES'(carry);

    res_d = {sign, exp_s[EXP_W-1:0], mant_r};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      res_d = QNAN;
      inv_d = 1'b1;
    end else if (inf_a || inf_b) begin
      res_d = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      res_d = {sign, {(W-1){1'b0}}};
    end else if (!exp_s[ES-1] && (exp_s >= EMAX_S)) begin
      res_d = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (exp_s[ES-1] || (exp_s == '0)) begin
      res_d = {sign, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end
  end

  // Control FSM and shift-add datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            mcand_q    <= PW'({1'b1, a[MAN_W-1:0]});
            mplier_q   <= {1'b1, b[MAN_W-1:0]};
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(MAN_W)) state_q <= NORM;
        end
        NORM: begin
          product_q   <= res_d;
          overflow_q  <= ovf_d;
          underflow_q <= unf_d;
          invalid_q   <= inv_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            invalid_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_fp_mult_iter.sv
// Directed and randomized bench for fp_mult_iter (single-precision defaults) with an arithmetic reference model.
module tb_fp_mult_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        overflow, underflow, invalid;

  int checks = 0;
  int errors = 0;

  fp_mult_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer significand product, then normalise/round by value.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ov,
                                output logic un, output logic iv);
    int     ex, ey, e;
    longint fx, fy, p, keep, rem, half;
    logic   s, nx, ny, ix, iy, zx, zy;
    ex = int'(x[30:23]);  ey = int'(y[30:23]);
    fx = longint'(x[22:0]); fy = longint'(y[22:0]);
    s  = x[31] ^ y[31];
    nx = (ex == 255) && (fx != 0);  ny = (ey == 255) && (fy != 0);
    ix = (ex == 255) && (fx == 0);  iy = (ey == 255) && (fy == 0);
    zx = (ex == 0);                 zy = (ey == 0);
    ov = 1'b0; un = 1'b0; iv = 1'b0;
    if (nx || ny || (ix && zy) || (iy && zx)) begin
      r = 32'h7fc00000; iv = 1'b1;
    end else if (ix || iy) begin
      r = {s, 8'hff, 23'h0};
    end else if (zx || zy) begin
      r = {s, 31'h0};
    end else begin
      p = (fx + (longint'(1) << 23)) * (fy + (longint'(1) << 23));
      e = ex + ey - 127;
      if (p >= (longint'(1) << 47)) begin
        e++;
        keep = p >> 24; rem = p % (longint'(1) << 24); half = longint'(1) << 23;
      end else begin
        keep = p >> 23; rem = p % (longint'(1) << 23); half = longint'(1) << 22;
      end
`ifdef FP_MULT_ROUND_NEAREST_EN
      if ((rem > half) || ((rem == half) && (keep % 2 == 1))) keep++;
      if (keep == (longint'(1) << 24)) begin keep = keep >> 1; e++; end
`else
      if (rem > half) keep = keep;
`endif
      if (e >= 255) begin
        r = {s, 8'hff, 23'h0}; ov = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'h0}; un = 1'b1;
      end else begin
        r = {s, 8'(e), 23'(keep)};
      end
    end
  endfunction

  // One full transaction: accept, latency, result, optional backpressure, release.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [31:0] er, input logic eo, input logic eu,
                        input logic ei, input int hold);
    int lat;
    lat = 0;
    while (!in_ready && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, " in_ready idle"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    a = ta; b = tbv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " in_ready busy"}, 64'(in_ready), 64'(0));
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, " latency"}, 64'(lat), 64'(25));
    chk({tag, " product"}, 64'(product), 64'(er));
    chk({tag, " flags ov/un/inv"}, 64'({overflow, underflow, invalid}), 64'({eo, eu, ei}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold product"}, 64'(product), 64'(er));
      chk({tag, " hold out_valid/in_ready"}, 64'({out_valid, in_ready}), 64'(2'b10));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " release"}, 64'({out_valid, in_ready, overflow, underflow, invalid}),
        64'(5'b01000));
  endtask

  initial begin
    logic [31:0] er, ra, rb;
    logic        eo, eu, ei;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", 64'({in_ready, out_valid, overflow, underflow, invalid}), 64'(5'b10000));
    chk("reset product", 64'(product), 64'(0));
    rst = 1'b0;

    run_op("one x 17.33", 32'h3f800000, 32'h418aa000, 32'h418aa000, 0, 0, 0, 0);
    run_op("-2 x 3",      32'hc0000000, 32'h40400000, 32'hc0c00000, 0, 0, 0, 0);
    run_op("zero x fin",  32'h00000000, 32'h418aa000, 32'h00000000, 0, 0, 0, 0);
    run_op("overflow",    32'h7f000000, 32'h40000000, 32'h7f800000, 1, 0, 0, 0);
    run_op("underflow",   32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 0);
    run_op("inf x 0",     32'h7f800000, 32'h00000000, 32'h7fc00000, 0, 0, 1, 0);
    run_op("-inf x 2",    32'hff800000, 32'h40000000, 32'hff800000, 0, 0, 0, 0);
    run_op("nan x 1",     32'h7f800001, 32'h3f800000, 32'h7fc00000, 0, 0, 1, 0);
    run_op("-0 x 5",      32'h80000000, 32'h40a00000, 32'h80000000, 0, 0, 0, 0);
`ifdef FP_MULT_ROUND_NEAREST_EN
    er = 32'h3fc00002;
`else
    er = 32'h3fc00001;
`endif
    run_op("round tie",   32'h3fc00000, 32'h3f800001, er, 0, 0, 0, 0);
    run_op("backpressure", 32'h40400000, 32'h40400000, 32'h41100000, 0, 0, 0, 10);

    // Abort mid-multiply, then confirm a clean follow-up operation.
    @(negedge clk);
    a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("abort state", 64'({in_ready, out_valid, overflow, underflow, invalid}), 64'(5'b10000));
    chk("abort product", 64'(product), 64'(0));
    run_op("after abort", 32'h40400000, 32'h40000000, 32'h40c00000, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 9) == 0) ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hff;
      else ra[30:23] = 8'($urandom_range(40, 215));
      if ($urandom_range(0, 9) == 0) rb[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hff;
      else rb[30:23] = 8'($urandom_range(40, 215));
      if ($urandom_range(0, 5) == 0) rb[22:0] = '0;
      model(ra, rb, er, eo, eu, ei);
      run_op($sformatf("rand%0d %h x %h", n, ra, rb), ra, rb, er, eo, eu, ei,
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
